// File: rtl/msrv32_trap_pkg.sv
// rtl/msrv32_trap_pkg.sv - shared encodings for the MSRV32 machine-mode trap controller
package msrv32_trap_pkg;

    typedef enum logic [2:0] {
        ST_RESET       = 3'd0,
        ST_OPERATING   = 3'd1,
        ST_TRAP_TAKEN  = 3'd2,
        ST_TRAP_RETURN = 3'd3,
        ST_WFI_SLEEP   = 3'd4
    } trap_state_t;

    localparam logic [1:0] PC_BOOT = 2'b00;
    localparam logic [1:0] PC_EPC  = 2'b01;
    localparam logic [1:0] PC_TRAP = 2'b10;
    localparam logic [1:0] PC_NEXT = 2'b11;

    localparam logic [4:0] CAUSE_INSTR_MISALIGNED = 5'd0;
    localparam logic [4:0] CAUSE_ILLEGAL          = 5'd2;
    localparam logic [4:0] CAUSE_BREAKPOINT       = 5'd3;
    localparam logic [4:0] CAUSE_LOAD_MISALIGNED  = 5'd4;
    localparam logic [4:0] CAUSE_STORE_MISALIGNED = 5'd6;
    localparam logic [4:0] CAUSE_ECALL_M          = 5'd11;
    localparam logic [4:0] CAUSE_MSI              = 5'd3;
    localparam logic [4:0] CAUSE_MTI              = 5'd7;
    localparam logic [4:0] CAUSE_MEI              = 5'd11;
    localparam logic [4:0] CAUSE_LOCAL_BASE       = 5'd16;

    localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;
    localparam logic [2:0] FUNCT3_PRIV   = 3'b000;
    localparam logic [6:0] FUNCT7_ECALL  = 7'b0000000;
    localparam logic [4:0] RS2_ECALL     = 5'b00000;
    localparam logic [4:0] RS2_EBREAK    = 5'b00001;
    localparam logic [6:0] FUNCT7_MRET   = 7'b0011000;
    localparam logic [4:0] RS2_MRET      = 5'b00010;
    localparam logic [6:0] FUNCT7_WFI    = 7'b0001000;
    localparam logic [4:0] RS2_WFI       = 5'b00101;

endpackage

// File: rtl/msrv32_irq_prio_enc.sv
// rtl/msrv32_irq_prio_enc.sv - fixed-priority interrupt resolver (local lines, MEI, MSI, MTI)
// Ports: std_pend_in/std_en_in {mei,msi,mti}; local_pend_in/local_en_in per local line;
//        valid_out = any enabled pending line; cause_out = winning cause code.
module msrv32_irq_prio_enc
    import msrv32_trap_pkg::*;
#(
    parameter int NUM_LOCAL_IRQ = 4,
    localparam int LW = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1
) (
    input  logic [2:0]    std_pend_in,
    input  logic [2:0]    std_en_in,
    input  logic [LW-1:0] local_pend_in,
    input  logic [LW-1:0] local_en_in,
    output logic          valid_out,
    output logic [4:0]    cause_out
);

    // Lowest priority is evaluated first so each later match overrides it.
    always_comb begin
        valid_out = 1'b0;
        cause_out = 5'd0;
        if (std_pend_in[0] && std_en_in[0]) begin
            valid_out = 1'b1;
            cause_out = CAUSE_MTI;
        end
        if (std_pend_in[1] && std_en_in[1]) begin
            valid_out = 1'b1;
            cause_out = CAUSE_MSI;
        end
        if (std_pend_in[2] && std_en_in[2]) begin
            valid_out = 1'b1;
            cause_out = CAUSE_MEI;
        end
        for (int k = 0; k < NUM_LOCAL_IRQ; k++) begin
            if (local_pend_in[k] && local_en_in[k]) begin
                valid_out = 1'b1;
                cause_out = CAUSE_LOCAL_BASE | 5'(k);
            end
        end
    end

endmodule

// File: rtl/msrv32_trap_controller.sv
// rtl/msrv32_trap_controller.sv - machine-mode trap FSM: exception/interrupt priority, trap vector, MRET/WFI
// Ports: clock/reset; exception flags and instruction fields; mstatus.MIE, mie/mip bits,
//        local enable/pending vectors, mtvec; outputs cause/i_or_e (registered), trap
//        address, pc_src select and one-cycle control strobes toward CSR file and pipeline.
module msrv32_trap_controller
    import msrv32_trap_pkg::*;
#(
    parameter int         NUM_LOCAL_IRQ = 4,
    parameter logic [1:0] RESET_PC_SRC  = 2'b00,
    localparam int        LW = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1
) (
    input  logic          ms_riscv32_mp_clk_in,
    input  logic          ms_riscv32_mp_rst_in,
    input  logic          illegal_instr_in,
    input  logic          misaligned_instr_in,
    input  logic          misaligned_load_in,
    input  logic          misaligned_store_in,
    input  logic [4:0]    opcode_6_to_2_in,
    input  logic [2:0]    funct3_in,
    input  logic [6:0]    funct7_in,
    input  logic [4:0]    rs1_addr_in,
    input  logic [4:0]    rs2_addr_in,
    input  logic [4:0]    rd_addr_in,
    input  logic          mie_in,
    input  logic          meie_in,
    input  logic          mtie_in,
    input  logic          msie_in,
    input  logic          meip_in,
    input  logic          mtip_in,
    input  logic          msip_in,
    input  logic [LW-1:0] local_irq_en_in,
    input  logic [LW-1:0] local_irq_pend_in,
    input  logic [29:0]   mtvec_base_in,
    input  logic          mtvec_mode_in,
    output logic          i_or_e_out,
    output logic [4:0]    cause_out,
    output logic [31:0]   trap_addr_out,
    output logic [1:0]    pc_src_out,
    output logic          trap_taken_out,
    output logic          set_epc_out,
    output logic          set_cause_out,
    output logic          mie_clear_out,
    output logic          mie_set_out,
    output logic          flush_out,
    output logic          instret_inc_out,
    output logic          misaligned_exception_out,
    output logic          stall_out
);

    trap_state_t state, next_state;

    logic       priv_instr;
    logic       is_ecall, is_ebreak, is_mret, is_wfi;
    logic       exc_valid;
    logic [4:0] exc_cause;
    logic       irq_valid;
    logic [4:0] irq_cause;
    logic       irq_take;
    logic       trap;
    logic [4:0] trap_cause;

    assign priv_instr = (opcode_6_to_2_in == OPCODE_SYSTEM) && (funct3_in == FUNCT3_PRIV) &&
                        (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    assign is_ecall   = priv_instr && (funct7_in == FUNCT7_ECALL) && (rs2_addr_in == RS2_ECALL);
    assign is_ebreak  = priv_instr && (funct7_in == FUNCT7_ECALL) && (rs2_addr_in == RS2_EBREAK);
    assign is_mret    = priv_instr && (funct7_in == FUNCT7_MRET)  && (rs2_addr_in == RS2_MRET);
    assign is_wfi     = priv_instr && (funct7_in == FUNCT7_WFI)   && (rs2_addr_in == RS2_WFI);

    always_comb begin
        exc_valid = 1'b1;
        exc_cause = 5'd0;
        if (misaligned_instr_in)       exc_cause = CAUSE_INSTR_MISALIGNED;
        else if (illegal_instr_in)     exc_cause = CAUSE_ILLEGAL;
        else if (is_ebreak)            exc_cause = CAUSE_BREAKPOINT;
        else if (is_ecall)             exc_cause = CAUSE_ECALL_M;
        else if (misaligned_load_in)   exc_cause = CAUSE_LOAD_MISALIGNED;
        else if (misaligned_store_in)  exc_cause = CAUSE_STORE_MISALIGNED;
        else                           exc_valid = 1'b0;
    end

    msrv32_irq_prio_enc #(.NUM_LOCAL_IRQ(NUM_LOCAL_IRQ)) u_prio (
        .std_pend_in   ({meip_in, msip_in, mtip_in}),
        .std_en_in     ({meie_in, msie_in, mtie_in}),
        .local_pend_in (local_irq_pend_in),
        .local_en_in   (local_irq_en_in),
        .valid_out     (irq_valid),
        .cause_out     (irq_cause)
    );

    // Interrupts beat any exception on the same instruction.
    assign irq_take   = mie_in && irq_valid;
    assign trap       = irq_take || exc_valid;
    assign trap_cause = irq_take ? irq_cause : exc_cause;

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state      <= ST_RESET;
            cause_out  <= 5'd0;
            i_or_e_out <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_OPERATING && trap) begin
                cause_out  <= trap_cause;
                i_or_e_out <= irq_take;
            end
        end
    end

    always_comb begin
        next_state               = state;
        pc_src_out               = PC_NEXT;
        trap_taken_out           = 1'b0;
        set_epc_out              = 1'b0;
        set_cause_out            = 1'b0;
        mie_clear_out            = 1'b0;
        mie_set_out              = 1'b0;
        flush_out                = 1'b0;
        instret_inc_out          = 1'b0;
        misaligned_exception_out = 1'b0;
        stall_out                = 1'b0;
        case (state)
            ST_RESET: begin
                pc_src_out = RESET_PC_SRC;
                next_state = ST_OPERATING;
            end
            ST_OPERATING: begin
                if (trap) begin
                    next_state     = ST_TRAP_TAKEN;
                    trap_taken_out = 1'b1;
                    set_epc_out    = 1'b1;
                    set_cause_out  = 1'b1;
                    mie_clear_out  = 1'b1;
                    flush_out      = 1'b1;
                    misaligned_exception_out = !irq_take &&
                        ((exc_cause == CAUSE_INSTR_MISALIGNED) ||
                         (exc_cause == CAUSE_LOAD_MISALIGNED) ||
                         (exc_cause == CAUSE_STORE_MISALIGNED));
                end else if (is_mret) begin
                    next_state      = ST_TRAP_RETURN;
                    flush_out       = 1'b1;
                    instret_inc_out = 1'b1;
                end else if (is_wfi && !irq_valid) begin
                    // WFI retires only on wake-up, so no instret pulse here.
                    next_state = ST_WFI_SLEEP;
                end else begin
                    instret_inc_out = 1'b1;
                end
            end
            ST_TRAP_TAKEN: begin
                pc_src_out = PC_TRAP;
                next_state = ST_OPERATING;
            end
            ST_TRAP_RETURN: begin
                pc_src_out  = PC_EPC;
                mie_set_out = 1'b1;
                next_state  = ST_OPERATING;
            end
            ST_WFI_SLEEP: begin
                stall_out = 1'b1;
                // Wake on any enabled pending line even with global MIE clear.
                if (irq_valid) next_state = ST_OPERATING;
            end
            default: next_state = ST_RESET;
        endcase
    end

    assign trap_addr_out = {mtvec_base_in, 2'b00} +
                           ((mtvec_mode_in && i_or_e_out) ? {25'd0, cause_out, 2'b00} : 32'd0);

endmodule

// File: tb/tb_msrv32_trap_controller.sv
// tb/tb_msrv32_trap_controller.sv - directed self-checking bench for msrv32_trap_controller
module tb_msrv32_trap_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        illegal, mis_instr, mis_load, mis_store;
    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
    logic        mie, meie, mtie, msie, meip, mtip, msip;
    logic [3:0]  local_en, local_pend;
    logic [29:0] mtvec_base;
    logic        mtvec_mode;
    logic        i_or_e;
    logic [4:0]  cause;
    logic [31:0] trap_addr;
    logic [1:0]  pc_src;
    logic        trap_taken, set_epc, set_cause, mie_clear, mie_set, flush, instret, mis_exc, stall;
    logic [8:0]  strobes;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign strobes = {trap_taken, set_epc, set_cause, mie_clear, mie_set, flush, instret, mis_exc, stall};

    msrv32_trap_controller #(.NUM_LOCAL_IRQ(4), .RESET_PC_SRC(2'b00)) dut (
        .ms_riscv32_mp_clk_in     (clk),
        .ms_riscv32_mp_rst_in     (rst),
        .illegal_instr_in         (illegal),
        .misaligned_instr_in      (mis_instr),
        .misaligned_load_in       (mis_load),
        .misaligned_store_in      (mis_store),
        .opcode_6_to_2_in         (opcode),
        .funct3_in                (funct3),
        .funct7_in                (funct7),
        .rs1_addr_in              (rs1),
        .rs2_addr_in              (rs2),
        .rd_addr_in               (rd),
        .mie_in                   (mie),
        .meie_in                  (meie),
        .mtie_in                  (mtie),
        .msie_in                  (msie),
        .meip_in                  (meip),
        .mtip_in                  (mtip),
        .msip_in                  (msip),
        .local_irq_en_in          (local_en),
        .local_irq_pend_in        (local_pend),
        .mtvec_base_in            (mtvec_base),
        .mtvec_mode_in            (mtvec_mode),
        .i_or_e_out               (i_or_e),
        .cause_out                (cause),
        .trap_addr_out            (trap_addr),
        .pc_src_out               (pc_src),
        .trap_taken_out           (trap_taken),
        .set_epc_out              (set_epc),
        .set_cause_out            (set_cause),
        .mie_clear_out            (mie_clear),
        .mie_set_out              (mie_set),
        .flush_out                (flush),
        .instret_inc_out          (instret),
        .misaligned_exception_out (mis_exc),
        .stall_out                (stall)
    );

    task automatic clear_inputs();
        {illegal, mis_instr, mis_load, mis_store} = 4'b0;
        opcode = 5'b01100; funct3 = 3'd0; funct7 = 7'd0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        {mie, meie, mtie, msie, meip, mtip, msip} = 7'b0;
        local_en = 4'b0; local_pend = 4'b0;
        mtvec_base = 30'd0; mtvec_mode = 1'b0;
    endtask

    // kind: 0 plain ALU op, 1 ECALL, 2 EBREAK, 3 MRET, 4 WFI
    task automatic set_instr(input int kind);
        opcode = (kind == 0) ? 5'b01100 : 5'b11100;
        funct3 = 3'd0; rs1 = 5'd0; rd = 5'd0;
        case (kind)
            1: begin funct7 = 7'b0000000; rs2 = 5'b00000; end
            2: begin funct7 = 7'b0000000; rs2 = 5'b00001; end
            3: begin funct7 = 7'b0011000; rs2 = 5'b00010; end
            4: begin funct7 = 7'b0001000; rs2 = 5'b00101; end
            default: begin funct7 = 7'd0; rs2 = 5'd3; end
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #12 rst = 1'b0;
        #1;
        total++; if (pc_src !== 2'b00) begin bad++; $display("FAIL reset_pc_src got %b exp 00", pc_src); end
        total++; if (strobes !== 9'b0) begin bad++; $display("FAIL reset_strobes got %b exp 000000000", strobes); end
        total++; if (cause !== 5'd0 || i_or_e !== 1'b0) begin bad++; $display("FAIL reset_cause got %0d/%b exp 0/0", cause, i_or_e); end
        @(posedge clk); #1;
        total++; if (pc_src !== 2'b11) begin bad++; $display("FAIL first_op_pc_src got %b exp 11", pc_src); end
        total++; if (strobes !== 9'b000000100) begin bad++; $display("FAIL first_op_strobes got %b exp 000000100", strobes); end
    endtask

    task automatic test_exceptions();
        // {mis_instr, illegal, mis_load, mis_store}
        logic [3:0] flags  [6] = '{4'b0110, 4'b0001, 4'b0011, 4'b0000, 4'b0010, 4'b1100};
        int         kind   [6] = '{0, 0, 0, 1, 2, 1};
        logic [4:0] ecause [6] = '{5'd2, 5'd6, 5'd4, 5'd11, 5'd3, 5'd0};
        logic       emis   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            mtvec_base = 30'h40; mtvec_mode = 1'b1;
            {mis_instr, illegal, mis_load, mis_store} = flags[i];
            set_instr(kind[i]);
            @(negedge clk);
            total++; if (strobes !== {7'b1111010, emis[i], 1'b0}) begin
                bad++; $display("FAIL exc%0d_strobes got %b exp %b", i, strobes, {7'b1111010, emis[i], 1'b0});
            end
            @(posedge clk); #1;
            total++; if (cause !== ecause[i] || i_or_e !== 1'b0) begin
                bad++; $display("FAIL exc%0d_cause got %0d/%b exp %0d/0", i, cause, i_or_e, ecause[i]);
            end
            total++; if (pc_src !== 2'b10 || trap_addr !== 32'h100) begin
                bad++; $display("FAIL exc%0d_target got pc_src=%b addr=%h exp 10/00000100", i, pc_src, trap_addr);
            end
            clear_inputs();
            @(posedge clk); #1;
            total++; if (pc_src !== 2'b11) begin bad++; $display("FAIL exc%0d_return_op got %b exp 11", i, pc_src); end
        end
    endtask

    task automatic test_interrupts();
        logic       m      [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] len    [7] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0010, 4'b0101};
        logic [3:0] lpend  [7] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0001, 4'b0101};
        logic [2:0] sen    [7] = '{3'b100, 3'b111, 3'b011, 3'b001, 3'b111, 3'b010, 3'b000};
        logic [2:0] spend  [7] = '{3'b100, 3'b111, 3'b011, 3'b001, 3'b111, 3'b011, 3'b000};
        logic       ill    [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       etaken [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [4:0] ecause [7] = '{5'd19, 5'd11, 5'd3, 5'd7, 5'd0, 5'd3, 5'd18};
        logic [31:0] eaddr;
        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            mtvec_base = 30'h100; mtvec_mode = 1'b1;
            mie = m[i]; local_en = len[i]; local_pend = lpend[i];
            {meie, msie, mtie} = sen[i]; {meip, msip, mtip} = spend[i];
            illegal = ill[i];
            @(negedge clk);
            if (etaken[i]) begin
                total++; if (strobes !== 9'b111101000) begin
                    bad++; $display("FAIL irq%0d_strobes got %b exp 111101000", i, strobes);
                end
                @(posedge clk); #1;
                eaddr = 32'h400 + {25'd0, ecause[i], 2'b00};
                total++; if (cause !== ecause[i] || i_or_e !== 1'b1) begin
                    bad++; $display("FAIL irq%0d_cause got %0d/%b exp %0d/1", i, cause, i_or_e, ecause[i]);
                end
                total++; if (pc_src !== 2'b10 || trap_addr !== eaddr) begin
                    bad++; $display("FAIL irq%0d_target got pc_src=%b addr=%h exp 10/%h", i, pc_src, trap_addr, eaddr);
                end
            end else begin
                total++; if (strobes !== 9'b000000100) begin
                    bad++; $display("FAIL irq%0d_masked_strobes got %b exp 000000100", i, strobes);
                end
                @(posedge clk); #1;
                total++; if (pc_src !== 2'b11) begin bad++; $display("FAIL irq%0d_masked_pc_src got %b exp 11", i, pc_src); end
            end
            clear_inputs();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_trap_addr();
        // Vectored offset wraps past 2^32.
        clear_inputs();
        mtvec_base = 30'h3FFF_FFFF; mtvec_mode = 1'b1;
        mie = 1'b1; local_en = 4'b1000; local_pend = 4'b1000;
        @(posedge clk); #1;
        total++; if (trap_addr !== 32'h0000_0048 || cause !== 5'd19) begin
            bad++; $display("FAIL addr_wrap got addr=%h cause=%0d exp 00000048/19", trap_addr, cause);
        end
        // Direct mode ignores the cause for interrupts.
        mtvec_mode = 1'b0; #1;
        total++; if (trap_addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL addr_direct got %h exp fffffffc", trap_addr);
        end
        clear_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_wfi();
        clear_inputs();
        set_instr(4);
        @(negedge clk);
        total++; if (strobes !== 9'b0) begin bad++; $display("FAIL wfi_enter_strobes got %b exp 000000000", strobes); end
        @(posedge clk); #1;
        set_instr(0);
        illegal = 1'b1;
        for (int c = 0; c < 5; c++) begin
            total++; if (strobes !== 9'b000000001 || pc_src !== 2'b11) begin
                bad++; $display("FAIL wfi_sleep%0d got strobes=%b pc_src=%b exp 000000001/11", c, strobes, pc_src);
            end
            if (c == 4) begin
                illegal = 1'b0;
                mie = 1'b1; mtie = 1'b1; mtip = 1'b1;
            end
            @(posedge clk); #1;
        end
        total++; if (strobes !== 9'b111101000) begin bad++; $display("FAIL wfi_wake_strobes got %b exp 111101000", strobes); end
        @(posedge clk); #1;
        total++; if (cause !== 5'd7 || i_or_e !== 1'b1 || pc_src !== 2'b10) begin
            bad++; $display("FAIL wfi_wake_trap got %0d/%b/%b exp 7/1/10", cause, i_or_e, pc_src);
        end
        // Wake-up with global MIE clear: leaves sleep but takes no trap.
        clear_inputs();
        @(posedge clk); #1;
        set_instr(4);
        @(posedge clk); #1;
        set_instr(0);
        msie = 1'b1; msip = 1'b1;
        @(posedge clk); #1;
        total++; if (strobes !== 9'b000000100) begin bad++; $display("FAIL wfi_wake_nomie got %b exp 000000100", strobes); end
        clear_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_mret();
        clear_inputs();
        set_instr(3);
        @(negedge clk);
        total++; if (strobes !== 9'b000001100) begin bad++; $display("FAIL mret_strobes got %b exp 000001100", strobes); end
        @(posedge clk); #1;
        set_instr(0);
        total++; if (pc_src !== 2'b01 || strobes !== 9'b000010000) begin
            bad++; $display("FAIL mret_return got pc_src=%b strobes=%b exp 01/000010000", pc_src, strobes);
        end
        @(posedge clk); #1;
        total++; if (pc_src !== 2'b11 || mie_set !== 1'b0) begin
            bad++; $display("FAIL mret_back got pc_src=%b mie_set=%b exp 11/0", pc_src, mie_set);
        end
    endtask

    task automatic test_reset_mid_trap();
        clear_inputs();
        mie = 1'b1; mtie = 1'b1; mtip = 1'b1;
        @(posedge clk); #1;
        total++; if (pc_src !== 2'b10 || i_or_e !== 1'b1) begin
            bad++; $display("FAIL rst_pre_trap got pc_src=%b i_or_e=%b exp 10/1", pc_src, i_or_e);
        end
        #2 rst = 1'b1;
        #1;
        total++; if (pc_src !== 2'b00 || cause !== 5'd0 || i_or_e !== 1'b0 || strobes !== 9'b0) begin
            bad++; $display("FAIL rst_async got pc_src=%b cause=%0d i_or_e=%b strobes=%b exp 00/0/0/0", pc_src, cause, i_or_e, strobes);
        end
        clear_inputs();
        @(negedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        total++; if (pc_src !== 2'b11 || strobes !== 9'b000000100) begin
            bad++; $display("FAIL rst_recover got pc_src=%b strobes=%b exp 11/000000100", pc_src, strobes);
        end
    endtask

    initial begin
        test_reset();
        test_exceptions();
        test_interrupts();
        test_trap_addr();
        test_wfi();
        test_mret();
        test_reset_mid_trap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
